rename_stage: RTL and testbench
===============================

RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 Parameter AR_W, default 5, architectural register index width; NUM_AR = 2**AR_W.
REQ-002 Parameter PR_W, default 8, physical register (RoB tag) width.
REQ-003 Parameter DATA_W, default 64, register data width; parameter PC_W, default 64, PC width.
REQ-004 The block SHALL have one clock and synchronous active-low reset: clock in 1, reset_n in 1.
REQ-005 Rename input: src1_ar, src2_ar, dst_ar in AR_W; has_dst in 1; pc_in in PC_W; valid_in in 1; in_ready out 1 (accept).
REQ-006 Dispatch output: src1_pr, src2_pr, dst_pr out PR_W; src1_dat, src2_dat out DATA_W; src1_valid, src2_valid out 1 (data from ARF); pc_out out PC_W; valid_out out 1; out_ready in 1.
REQ-007 RoB allocate: next_free in PR_W; is_free in 1; alloc_arf out AR_W; alloc_pc out PC_W; do_alloc out 1.
REQ-008 RoB commit: commit_arf in AR_W; commit_prf in PR_W; commit_result in DATA_W; commit_valid in 1.
REQ-009 Recovery: flush in 1, discards all speculative mappings.

Function
REQ-010 State: RAT (NUM_AR x PR_W), in_prf (NUM_AR bits), ARF (NUM_AR x DATA_W), one output pipeline register.
REQ-011 in_ready SHALL be combinational: is_free && (out_ready || !valid_out) && !flush.
REQ-012 Accept = valid_in && in_ready; do_alloc = accept && has_dst; alloc_arf = dst_ar; alloc_pc = pc_in.
REQ-013 On accept, next cycle: srcN_pr = RAT[srcN_ar], srcN_dat = ARF[srcN_ar], srcN_valid = !in_prf[srcN_ar], dst_pr = next_free (0 if !has_dst), pc_out = pc_in, valid_out = 1; latency exactly 1 cycle.
REQ-014 Output register SHALL hold all fields stable while valid_out && !out_ready; valid_out clears when out_ready and no accept.
REQ-015 On do_alloc with dst_ar != 0: RAT[dst_ar] <= next_free, in_prf[dst_ar] <= 1.
REQ-016 Arch register 0 is hardwired zero: never renamed, never written; src reads return dat 0, valid 1.
REQ-017 Sources read RAT/in_prf state from before the same-cycle destination update (src == dst reads old mapping).
REQ-018 On commit_valid with commit_arf != 0: ARF[commit_arf] <= commit_result.
REQ-019 On commit: if RAT[commit_arf] == commit_prf and in_prf set, clear in_prf[commit_arf]; otherwise leave it.
REQ-020 Simultaneous alloc and commit to same AR: alloc wins; in_prf stays 1, RAT takes next_free.
REQ-021 flush: clear all in_prf bits and valid_out next cycle; ARF kept; a same-cycle commit still writes ARF; flush overrides alloc.
REQ-022 is_free low SHALL stall (in_ready 0) with no do_alloc and no RAT change.

Reset
REQ-023 On clock edge with reset_n low: valid_out 0, all in_prf 0, all output data/tag registers 0, all ARF entries 0; RAT contents don't-care.
REQ-024 Reset mid-stall SHALL drop the held instruction; in_ready reflects reset values the cycle after release.

Configuration
REQ-025 Macro RENAME_COMMIT_BYPASS_EN defined: when accept and commit_valid in the same cycle and srcN_ar == commit_arf (non-zero) and RAT[srcN_ar] == commit_prf with in_prf set, srcN_dat = commit_result and srcN_valid = 1.
REQ-026 Macro undefined: no bypass; that source gets srcN_valid = 0 and srcN_pr = commit_prf (value from RoB).

Verification
REQ-027 Reset, then rename src1=3, src2=4, dst=5, next_free=0x21 -> next cycle src1/2_valid=1, dat=0, dst_pr=0x21, do_alloc pulsed 1 cycle.
REQ-028 Back-to-back: dst=5 tag 0x21 then src1=5 -> src1_pr=0x21, src1_valid=0; commit (5,0x21,0xDEAD) then src1=5 -> valid=1, dat 0xDEAD.
REQ-029 Stale commit: rename r5 to 0x21 then 0x22; commit (5,0x21) -> in_prf[5] stays 1, later read gives pr 0x22 valid 0.
REQ-030 Same-cycle commit (5,0x21) and rename src1=5 -> bypass on: dat=commit_result valid 1; bypass off: valid 0, pr 0x21.
REQ-031 out_ready low 3 cycles with valid_in high -> outputs held, in_ready 0, no do_alloc; is_free low -> no accept.
REQ-032 flush after 4 renames -> all sources read valid=1 with ARF data; dst=0 rename -> no RAT change, do_alloc 0 if has_dst 0.

Source files
------------

// File: rtl/rename_if.sv
// Rename-stage bus: rename request, dispatch output, RoB allocate/commit and flush.
// The rename stage connects through the slave modport; the surrounding pipeline uses master.
interface rename_if #(
  parameter int unsigned AR_W   = 5,
  parameter int unsigned PR_W   = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PC_W   = 64
);
  logic [AR_W-1:0]   src1_ar;
  logic [AR_W-1:0]   src2_ar;
  logic [AR_W-1:0]   dst_ar;
  logic              has_dst;
  logic [PC_W-1:0]   pc_in;
  logic              valid_in;
  logic              in_ready;

  logic [PR_W-1:0]   src1_pr;
  logic [PR_W-1:0]   src2_pr;
  logic [PR_W-1:0]   dst_pr;
  logic [DATA_W-1:0] src1_dat;
  logic [DATA_W-1:0] src2_dat;
  logic              src1_valid;
  logic              src2_valid;
  logic [PC_W-1:0]   pc_out;
  logic              valid_out;
  logic              out_ready;

  logic [PR_W-1:0]   next_free;
  logic              is_free;
  logic [AR_W-1:0]   alloc_arf;
  logic [PC_W-1:0]   alloc_pc;
  logic              do_alloc;

  logic [AR_W-1:0]   commit_arf;
  logic [PR_W-1:0]   commit_prf;
  logic [DATA_W-1:0] commit_result;
  logic              commit_valid;

  logic              flush;

  modport slave (
    input  src1_ar, src2_ar, dst_ar, has_dst, pc_in, valid_in,
    output in_ready,
    output src1_pr, src2_pr, dst_pr, src1_dat, src2_dat, src1_valid, src2_valid, pc_out,
    output valid_out,
    input  out_ready,
    input  next_free, is_free,
    output alloc_arf, alloc_pc, do_alloc,
    input  commit_arf, commit_prf, commit_result, commit_valid,
    input  flush
  );

  modport master (
    output src1_ar, src2_ar, dst_ar, has_dst, pc_in, valid_in,
    input  in_ready,
    input  src1_pr, src2_pr, dst_pr, src1_dat, src2_dat, src1_valid, src2_valid, pc_out,
    input  valid_out,
    output out_ready,
    output next_free, is_free,
    input  alloc_arf, alloc_pc, do_alloc,
    output commit_arf, commit_prf, commit_result, commit_valid,
    output flush
  );
endinterface

// File: rtl/rename_stage.sv
// Register rename stage: RAT + in-flight bits + ARF with a one-deep dispatch register.
// Optional macro RENAME_COMMIT_BYPASS_EN forwards same-cycle commit data to sources.
module rename_stage #(
  parameter int unsigned AR_W   = 5,
  parameter int unsigned PR_W   = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PC_W   = 64
) (
  input logic      clock,
  input logic      reset_n,
  rename_if.slave  bus
);
  localparam int unsigned NUM_AR = 2 ** AR_W;

  typedef struct packed {
    logic [PR_W-1:0]   src1_pr;
    logic [PR_W-1:0]   src2_pr;
    logic [PR_W-1:0]   dst_pr;
    logic [DATA_W-1:0] src1_dat;
    logic [DATA_W-1:0] src2_dat;
    logic              src1_valid;
    logic              src2_valid;
    logic [PC_W-1:0]   pc;
  } out_t;

  logic [PR_W-1:0]   rat_q [NUM_AR];
  logic [DATA_W-1:0] arf_q [NUM_AR];
  logic [NUM_AR-1:0] in_prf_q, in_prf_d;
  out_t              out_q, out_d;
  logic              valid_q, valid_d;

  logic              accept;
  logic              commit_hit;
  logic [AR_W-1:0]   src_ar  [2];
  logic [PR_W-1:0]   src_pr  [2];
  logic [DATA_W-1:0] src_dat [2];
  logic              src_vld [2];

  assign bus.in_ready  = bus.is_free && (bus.out_ready || !valid_q) && !bus.flush;
  assign accept        = bus.valid_in && bus.in_ready;
  assign bus.do_alloc  = accept && bus.has_dst;
  assign bus.alloc_arf = bus.dst_ar;
  assign bus.alloc_pc  = bus.pc_in;

  // Commit retires the youngest mapping only if the RAT still points at that tag.
  assign commit_hit = bus.commit_valid && (bus.commit_arf != '0) &&
                      (rat_q[bus.commit_arf] == bus.commit_prf) && in_prf_q[bus.commit_arf];

  assign src_ar[0] = bus.src1_ar;
  assign src_ar[1] = bus.src2_ar;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_pr[i]  = rat_q[src_ar[i]];
      src_dat[i] = arf_q[src_ar[i]];
      src_vld[i] = !in_prf_q[src_ar[i]];
      if (src_ar[i] == '0) begin
        src_pr[i]  = '0;
        src_dat[i] = '0;
        src_vld[i] = 1'b1;
      end
`ifdef RENAME_COMMIT_BYPASS_EN
      else if (commit_hit && (src_ar[i] == bus.commit_arf)) begin
        src_dat[i] = bus.commit_result;
        src_vld[i] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d          = 1'b1;
      out_d.src1_pr    = src_pr[0];
      out_d.src2_pr    = src_pr[1];
      out_d.src1_dat   = src_dat[0];
      out_d.src2_dat   = src_dat[1];
      out_d.src1_valid = src_vld[0];
      out_d.src2_valid = src_vld[1];
      out_d.dst_pr     = bus.has_dst ? bus.next_free : '0;
      out_d.pc         = bus.pc_in;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Alloc is applied after the commit clear so it wins on the same register.
  always_comb begin
    in_prf_d = in_prf_q;
    if (bus.flush) begin
      in_prf_d = '0;
    end else begin
      if (commit_hit) in_prf_d[bus.commit_arf] = 1'b0;
      if (bus.do_alloc && (bus.dst_ar != '0)) in_prf_d[bus.dst_ar] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      out_q    <= '0;
      in_prf_q <= '0;
      for (int i = 0; i < NUM_AR; i++) arf_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      out_q    <= out_d;
      in_prf_q <= in_prf_d;
      if (bus.commit_valid && (bus.commit_arf != '0)) arf_q[bus.commit_arf] <= bus.commit_result;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && bus.do_alloc && (bus.dst_ar != '0)) rat_q[bus.dst_ar] <= bus.next_free;
  end

  assign bus.src1_pr    = out_q.src1_pr;
  assign bus.src2_pr    = out_q.src2_pr;
  assign bus.dst_pr     = out_q.dst_pr;
  assign bus.src1_dat   = out_q.src1_dat;
  assign bus.src2_dat   = out_q.src2_dat;
  assign bus.src1_valid = out_q.src1_valid;
  assign bus.src2_valid = out_q.src2_valid;
  assign bus.pc_out     = out_q.pc;
  assign bus.valid_out  = valid_q;
endmodule

// File: tb/tb_rename_stage.sv
// Directed self-checking bench for rename_stage; honours RENAME_COMMIT_BYPASS_EN like the RTL.
module tb_rename_stage;
  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  rename_if #(.AR_W(5), .PR_W(8), .DATA_W(64), .PC_W(64)) bus ();

  rename_stage #(.AR_W(5), .PR_W(8), .DATA_W(64), .PC_W(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.valid_in     = 1'b0;
    bus.has_dst      = 1'b0;
    bus.src1_ar      = '0;
    bus.src2_ar      = '0;
    bus.dst_ar       = '0;
    bus.pc_in        = '0;
    bus.next_free    = '0;
    bus.is_free      = 1'b1;
    bus.out_ready    = 1'b1;
    bus.commit_valid = 1'b0;
    bus.commit_arf   = '0;
    bus.commit_prf   = '0;
    bus.commit_result = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic ren(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                     input logic hd, input logic [7:0] nf, input logic [63:0] pc);
    bus.valid_in  = 1'b1;
    bus.src1_ar   = s1;
    bus.src2_ar   = s2;
    bus.dst_ar    = d;
    bus.has_dst   = hd;
    bus.next_free = nf;
    bus.pc_in     = pc;
  endtask

  task automatic cmt(input logic [4:0] ar, input logic [7:0] pr, input logic [63:0] res);
    bus.commit_valid  = 1'b1;
    bus.commit_arf    = ar;
    bus.commit_prf    = pr;
    bus.commit_result = res;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    chk("reset_valid_out", 64'(bus.valid_out), 64'd0);
    chk("reset_dst_pr", 64'(bus.dst_pr), 64'd0);
    chk("reset_src1_dat", bus.src1_dat, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic rename
    ren(5'd3, 5'd4, 5'd5, 1'b1, 8'h21, 64'h1000);
    #1;
    chk("r1_do_alloc", 64'(bus.do_alloc), 64'd1);
    chk("r1_alloc_arf", 64'(bus.alloc_arf), 64'd5);
    chk("r1_alloc_pc", bus.alloc_pc, 64'h1000);
    tick();
    chk("r1_valid_out", 64'(bus.valid_out), 64'd1);
    chk("r1_src1_valid", 64'(bus.src1_valid), 64'd1);
    chk("r1_src2_valid", 64'(bus.src2_valid), 64'd1);
    chk("r1_src1_dat", bus.src1_dat, 64'd0);
    chk("r1_dst_pr", 64'(bus.dst_pr), 64'h21);
    chk("r1_pc_out", bus.pc_out, 64'h1000);

    // Back-to-back dependent read
    ren(5'd5, 5'd0, 5'd0, 1'b0, 8'h99, 64'h1004);
    #1;
    chk("r2_do_alloc_nodst", 64'(bus.do_alloc), 64'd0);
    tick();
    chk("r2_src1_pr", 64'(bus.src1_pr), 64'h21);
    chk("r2_src1_valid", 64'(bus.src1_valid), 64'd0);
    chk("r2_src2_valid_r0", 64'(bus.src2_valid), 64'd1);
    chk("r2_dst_pr_nodst", 64'(bus.dst_pr), 64'd0);

    idle();
    cmt(5'd5, 8'h21, 64'hDEAD);
    tick();
    chk("c1_valid_out_clr", 64'(bus.valid_out), 64'd0);
    idle();
    ren(5'd5, 5'd0, 5'd0, 1'b0, 8'h00, 64'h1008);
    tick();
    chk("c1_src1_valid", 64'(bus.src1_valid), 64'd1);
    chk("c1_src1_dat", bus.src1_dat, 64'hDEAD);

    // Stale commit keeps the younger mapping in flight
    ren(5'd0, 5'd0, 5'd5, 1'b1, 8'h21, 64'h2000);
    tick();
    ren(5'd0, 5'd0, 5'd5, 1'b1, 8'h22, 64'h2004);
    tick();
    idle();
    cmt(5'd5, 8'h21, 64'hBEEF);
    tick();
    idle();
    ren(5'd5, 5'd0, 5'd0, 1'b0, 8'h00, 64'h2008);
    tick();
    chk("stale_src1_pr", 64'(bus.src1_pr), 64'h22);
    chk("stale_src1_valid", 64'(bus.src1_valid), 64'd0);
    chk("stale_src1_dat", bus.src1_dat, 64'hBEEF);
    idle();
    cmt(5'd5, 8'h22, 64'hCAFE);
    tick();
    idle();

    // Same-cycle commit and read
    ren(5'd0, 5'd0, 5'd5, 1'b1, 8'h21, 64'h3000);
    tick();
    ren(5'd5, 5'd0, 5'd0, 1'b0, 8'h00, 64'h3004);
    cmt(5'd5, 8'h21, 64'h1234);
    tick();
    chk("byp_src1_pr", 64'(bus.src1_pr), 64'h21);
`ifdef RENAME_COMMIT_BYPASS_EN
    chk("byp_src1_valid", 64'(bus.src1_valid), 64'd1);
    chk("byp_src1_dat", bus.src1_dat, 64'h1234);
`else
    chk("byp_src1_valid", 64'(bus.src1_valid), 64'd0);
    chk("byp_src1_dat", bus.src1_dat, 64'hCAFE);
`endif
    idle();

    // Alloc and commit to the same register in one cycle: alloc wins
    ren(5'd0, 5'd0, 5'd5, 1'b1, 8'h60, 64'h3100);
    tick();
    ren(5'd0, 5'd0, 5'd5, 1'b1, 8'h61, 64'h3104);
    cmt(5'd5, 8'h60, 64'h5555);
    tick();
    idle();
    ren(5'd5, 5'd0, 5'd0, 1'b0, 8'h00, 64'h3108);
    tick();
    chk("aw_src1_pr", 64'(bus.src1_pr), 64'h61);
    chk("aw_src1_valid", 64'(bus.src1_valid), 64'd0);
    chk("aw_src1_dat", bus.src1_dat, 64'h5555);

    // Back-pressure: held outputs, no accept
    ren(5'd3, 5'd0, 5'd6, 1'b1, 8'h30, 64'h4000);
    tick();
    ren(5'd7, 5'd7, 5'd7, 1'b1, 8'h31, 64'h5000);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_do_alloc", 64'(bus.do_alloc), 64'd0);
      tick();
      chk("bp_pc_held", bus.pc_out, 64'h4000);
      chk("bp_dst_held", 64'(bus.dst_pr), 64'h30);
      chk("bp_valid_held", 64'(bus.valid_out), 64'd1);
    end
    idle();
    tick();
    chk("bp_drain", 64'(bus.valid_out), 64'd0);
    ren(5'd7, 5'd0, 5'd7, 1'b1, 8'h32, 64'h5004);
    bus.is_free = 1'b0;
    #1;
    chk("nf_in_ready", 64'(bus.in_ready), 64'd0);
    chk("nf_do_alloc", 64'(bus.do_alloc), 64'd0);
    tick();
    chk("nf_valid_out", 64'(bus.valid_out), 64'd0);
    idle();
    ren(5'd7, 5'd0, 5'd0, 1'b0, 8'h00, 64'h5008);
    tick();
    chk("nf_r7_valid", 64'(bus.src1_valid), 64'd1);

    // Flush after four renames
    for (int i = 1; i <= 4; i++) begin
      ren(5'd0, 5'd0, 5'(i), 1'b1, 8'(8'h40 + i), 64'h6000 + 64'(i));
      tick();
    end
    ren(5'd1, 5'd2, 5'd6, 1'b1, 8'h70, 64'h6010);
    cmt(5'd2, 8'h42, 64'h77);
    bus.flush = 1'b1;
    #1;
    chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
    chk("fl_do_alloc", 64'(bus.do_alloc), 64'd0);
    tick();
    chk("fl_valid_out", 64'(bus.valid_out), 64'd0);
    idle();
    ren(5'd1, 5'd2, 5'd0, 1'b0, 8'h00, 64'h6014);
    tick();
    chk("fl_r1_valid", 64'(bus.src1_valid), 64'd1);
    chk("fl_r2_valid", 64'(bus.src2_valid), 64'd1);
    chk("fl_r2_dat", bus.src2_dat, 64'h77);
    ren(5'd5, 5'd6, 5'd0, 1'b0, 8'h00, 64'h6018);
    tick();
    chk("fl_r5_valid", 64'(bus.src1_valid), 64'd1);
    chk("fl_r5_dat", bus.src1_dat, 64'h5555);
    chk("fl_r6_valid", 64'(bus.src2_valid), 64'd1);

    // Destination r0
    ren(5'd0, 5'd0, 5'd0, 1'b1, 8'h50, 64'h7000);
    #1;
    chk("d0_do_alloc", 64'(bus.do_alloc), 64'd1);
    tick();
    chk("d0_dst_pr", 64'(bus.dst_pr), 64'h50);
    ren(5'd0, 5'd0, 5'd0, 1'b0, 8'h00, 64'h7004);
    tick();
    chk("d0_src1_pr", 64'(bus.src1_pr), 64'd0);
    chk("d0_src1_valid", 64'(bus.src1_valid), 64'd1);
    chk("d0_src1_dat", bus.src1_dat, 64'd0);

    // Reset while stalled
    ren(5'd1, 5'd0, 5'd9, 1'b1, 8'h90, 64'h8000);
    tick();
    bus.out_ready = 1'b0;
    ren(5'd2, 5'd0, 5'd10, 1'b1, 8'h91, 64'h8004);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    chk("rs_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rs_dst_pr", 64'(bus.dst_pr), 64'd0);
    chk("rs_in_ready", 64'(bus.in_ready), 64'd1);
    idle();
    ren(5'd9, 5'd0, 5'd0, 1'b0, 8'h00, 64'h8008);
    tick();
    chk("rs_r9_valid", 64'(bus.src1_valid), 64'd1);
    chk("rs_r9_dat", bus.src1_dat, 64'd0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
